// File: rtl/issue_gate_pkg.sv
// Shared types and constants for the issue-gate contract sequencer.
// The state encodings are shared so the debug port can be decoded outside the block.
package issue_gate_pkg;

    localparam int STAMP_W   = 32;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_GAP_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Decoded view of the encodings above, for debug/trace consumers.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_GAP_W-1:0] gap;
    } gate_cmd_t;

endpackage

// File: rtl/issue_trace_fifo.sv
// Small synchronous FIFO that holds issue cycle stamps; the head is read from registers.
// DEPTH must be a power of two, at least 2.  A push on full is accepted only with a pop in the same cycle.
module issue_trace_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/issue_gate_ctrl.sv
// Contract-test sequencer: releases exactly N core issues with a programmable bubble gap and a watchdog.
// Optional issue trace FIFO (cycle stamps) is built only when ISSUE_TRACE_EN is defined.
// Command port: a command transfers on a cycle where cmd_valid_i && cmd_ready_o; ready is high only in IDLE.
module issue_gate_ctrl
    import issue_gate_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GAP_W       = DEF_GAP_W,
`ifdef ISSUE_TRACE_EN
    parameter int TRACE_DEPTH = 8,
`endif
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [CNT_W-1:0]   cmd_count_i,
    input  logic [GAP_W-1:0]   cmd_gap_i,
    input  logic               abort_i,
    output logic               enable_issue_o,
    input  logic               issue_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic               proto_err_o,
    output logic [CNT_W-1:0]   issued_cnt_o,
`ifdef ISSUE_TRACE_EN
    output logic               trace_valid_o,
    input  logic               trace_ready_i,
    output logic [STAMP_W-1:0] trace_stamp_o,
    output logic               trace_ovf_o,
`endif
    output logic [1:0]         dbg_state_o
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic             perr_q, perr_d;
    logic             accept, counted;

    assign accept  = cmd_valid_i && (state_q == ST_IDLE);
    assign counted = issue_i && (state_q == ST_RUN);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        issued_d  = issued_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        perr_d    = perr_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    count_d   = cmd_count_i;
                    gap_d     = cmd_gap_i;
                    issued_d  = '0;
                    wd_d      = '0;
                    timeout_d = 1'b0;
                    perr_d    = 1'b0;
                    state_d   = (cmd_count_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // A same-cycle issue is always counted, even against abort or watchdog expiry.
                if (issue_i) begin
                    issued_d = issued_q + 1'b1;
                    wd_d     = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (issue_i) begin
                    if (issued_q + 1'b1 == count_q) begin
                        state_d = ST_DONE;
                    end else if (gap_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_GAP: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Any issue outside RUN breaks the contract, even one in the accept cycle.
        if (issue_i && (state_q != ST_RUN)) perr_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            issued_q  <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            issued_q  <= issued_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            perr_q    <= perr_d;
        end
    end

    assign cmd_ready_o    = (state_q == ST_IDLE);
    assign enable_issue_o = (state_q == ST_RUN);
    assign busy_o         = (state_q == ST_RUN) || (state_q == ST_GAP);
    assign done_o         = (state_q == ST_DONE);
    assign timeout_o      = timeout_q;
    assign proto_err_o    = perr_q;
    assign issued_cnt_o   = issued_q;
    assign dbg_state_o    = state_q;

`ifdef ISSUE_TRACE_EN
    logic [STAMP_W-1:0] stamp_q;
    logic               ovf_q;
    logic               fifo_full, fifo_empty;

    // Overflow is flagged only when the FIFO cannot make room by a same-cycle pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stamp_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            stamp_q <= stamp_q + 1'b1;
            if (accept)
                ovf_q <= 1'b0;
            else if (counted && fifo_full && !(trace_ready_i && !fifo_empty))
                ovf_q <= 1'b1;
        end
    end

    issue_trace_fifo #(
        .W     (STAMP_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (counted),
        .data_i  (stamp_q),
        .pop_i   (trace_ready_i),
        .data_o  (trace_stamp_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign trace_valid_o = !fifo_empty;
    assign trace_ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_issue_gate_ctrl.sv
// Directed bench for issue_gate_ctrl with a behavioural core model and a done-result scoreboard.
// Trace checks are compiled in when ISSUE_TRACE_EN is defined.
module tb_issue_gate_ctrl;
    import issue_gate_pkg::*;

    localparam int CNT_W = 16;
    localparam int GAP_W = 8;
    localparam int TMO   = 16;
    localparam int DEPTH = 8;
    localparam int W     = 17;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [CNT_W-1:0] cmd_count_i = '0;
    logic [GAP_W-1:0] cmd_gap_i = '0;
    logic             abort_i = 1'b0;
    logic             enable_issue_o;
    logic             issue_i = 1'b0;
    logic             busy_o, done_o, timeout_o, proto_err_o;
    logic [CNT_W-1:0] issued_cnt_o;
    logic [1:0]       dbg_state_o;
`ifdef ISSUE_TRACE_EN
    logic             trace_valid_o;
    logic             trace_ready_i = 1'b0;
    logic [31:0]      trace_stamp_o;
    logic             trace_ovf_o;
`endif

    issue_gate_ctrl #(
        .CNT_W       (CNT_W),
        .GAP_W       (GAP_W),
`ifdef ISSUE_TRACE_EN
        .TRACE_DEPTH (DEPTH),
`endif
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_count_i    (cmd_count_i),
        .cmd_gap_i      (cmd_gap_i),
        .abort_i        (abort_i),
        .enable_issue_o (enable_issue_o),
        .issue_i        (issue_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o),
        .proto_err_o    (proto_err_o),
        .issued_cnt_o   (issued_cnt_o),
`ifdef ISSUE_TRACE_EN
        .trace_valid_o  (trace_valid_o),
        .trace_ready_i  (trace_ready_i),
        .trace_stamp_o  (trace_stamp_o),
        .trace_ovf_o    (trace_ovf_o),
`endif
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Each done pulse presents {timeout, issued_cnt} for the command just finished.
    always @(negedge clk) begin
        if (!rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done_unexpected: got done with issued_cnt %0d, expected no done", issued_cnt_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_result", 32'({timeout_o, issued_cnt_o}), 32'(mon_e));
            end
        end
    end

    // ---------------- core model ----------------
    int           budget = 0;
    int           abort_at = 0;
    int           core_issued = 0;
    bit           force_issue = 1'b0;
    bit           trace_on = 1'b0;
    logic [63:0]  en_bits = '0;
    int           en_n = 0;
    logic [31:0]  cyc = '0;
    logic [31:0]  stamp_exp[$];

    always @(posedge clk) begin
        if (rst_i) cyc <= '0;
        else       cyc <= cyc + 1;
    end

    // Issues are driven on the falling edge so they are stable at the next rising edge.
    always @(negedge clk) begin
        issue_i = 1'b0;
        abort_i = 1'b0;
        if (busy_o) begin
            en_bits = {en_bits[62:0], enable_issue_o};
            en_n++;
        end
        if (force_issue) begin
            issue_i = 1'b1;
        end else if (enable_issue_o && budget > 0) begin
            issue_i = 1'b1;
            budget--;
            core_issued++;
            if (core_issued == abort_at) abort_i = 1'b1;
            if (trace_on && stamp_exp.size() < DEPTH) stamp_exp.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int cnt, input int gap, input int bud, input int ab);
        int k;
        k = 0;
        while (!cmd_ready_o && k < 200) begin
            tick();
            k++;
        end
        check("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
        budget      = bud;
        abort_at    = ab;
        core_issued = 0;
        en_bits     = '0;
        en_n        = 0;
        cmd_valid_i = 1'b1;
        cmd_count_i = CNT_W'(cnt);
        cmd_gap_i   = GAP_W'(gap);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done_o && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, 32'(done_o), 32'd1);
        tick();
    endtask

    task automatic check_reset(input string name);
        check({name, "_ready"},   32'(cmd_ready_o),    32'd1);
        check({name, "_enable"},  32'(enable_issue_o), 32'd0);
        check({name, "_busy"},    32'(busy_o),         32'd0);
        check({name, "_done"},    32'(done_o),         32'd0);
        check({name, "_timeout"}, 32'(timeout_o),      32'd0);
        check({name, "_perr"},    32'(proto_err_o),    32'd0);
        check({name, "_issued"},  32'(issued_cnt_o),   32'd0);
        check({name, "_state"},   32'(dbg_state_o),    32'(ST_IDLE));
`ifdef ISSUE_TRACE_EN
        check({name, "_tvalid"},  32'(trace_valid_o),  32'd0);
        check({name, "_tovf"},    32'(trace_ovf_o),    32'd0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_i = 1'b1;
        tick();
        check_reset("reset");
        tick();
        rst_i = 1'b0;
        tick();

        // Back-to-back release of three.
        exp_q.push_back({1'b0, 16'd3});
        send(3, 0, 100, 0);
        wait_done("t1");
        check("t1_en_cycles", 32'(en_n), 32'd3);
        check("t1_en_bits", 32'(en_bits[2:0]), 32'h7);
        check("t1_hold_cnt", 32'(issued_cnt_o), 32'd3);
        check("t1_perr", 32'(proto_err_o), 32'd0);

        // Gap of four low cycles between two issues.
        exp_q.push_back({1'b0, 16'd2});
        send(2, 4, 100, 0);
        wait_done("t2");
        check("t2_en_cycles", 32'(en_n), 32'd6);
        check("t2_en_bits", 32'(en_bits[5:0]), 32'b100001);

        // Core stalls after two issues: watchdog fires after 16 quiet RUN cycles.
        exp_q.push_back({1'b1, 16'd2});
        send(5, 0, 2, 0);
        wait_done("t3");
        check("t3_en_cycles", 32'(en_n), 32'd18);
        check("t3_en_bits", 32'(en_bits[17:0]), 32'h3ffff);
        check("t3_timeout_sticky", 32'(timeout_o), 32'd1);

        // Abort together with the fourth issue.
        exp_q.push_back({1'b0, 16'd4});
        send(10, 0, 100, 4);
        check("t4_timeout_cleared", 32'(timeout_o), 32'd0);
        wait_done("t4");
        check("t4_en_cycles", 32'(en_n), 32'd4);
        check("t4_en_bits", 32'(en_bits[3:0]), 32'hf);

        // Zero-count command goes straight to DONE.
        exp_q.push_back({1'b0, 16'd0});
        send(0, 0, 100, 0);
        check("t5_done_now", 32'(done_o), 32'd1);
        check("t5_enable", 32'(enable_issue_o), 32'd0);
        wait_done("t5");
        check("t5_en_cycles", 32'(en_n), 32'd0);

        // Stray issue in IDLE is a protocol error until the next accept.
        check("t5_perr_before", 32'(proto_err_o), 32'd0);
        force_issue = 1'b1;
        tick();
        force_issue = 1'b0;
        check("t5_perr_set", 32'(proto_err_o), 32'd1);
        tick();
        check("t5_perr_sticky", 32'(proto_err_o), 32'd1);
        check("t5_issued_unchanged", 32'(issued_cnt_o), 32'd0);
        exp_q.push_back({1'b0, 16'd1});
        send(1, 0, 100, 0);
        check("t5_perr_cleared", 32'(proto_err_o), 32'd0);
        wait_done("t5b");

        // Reset in the middle of a long command.
        send(20, 0, 100, 0);
        tick();
        tick();
        check("rst_mid_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        tick();
        check_reset("rst_mid");
        rst_i = 1'b0;
        tick();

`ifdef ISSUE_TRACE_EN
        // Ten issues into an eight-deep FIFO with no pops.
        trace_on = 1'b1;
        exp_q.push_back({1'b0, 16'd10});
        send(10, 0, 100, 0);
        wait_done("t6");
        trace_on = 1'b0;
        check("t6_ovf", 32'(trace_ovf_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("t6_tvalid", 32'(trace_valid_o), 32'd1);
            if (stamp_exp.size() > 0) check("t6_stamp", trace_stamp_o, stamp_exp.pop_front());
            trace_ready_i = 1'b1;
            tick();
            trace_ready_i = 1'b0;
        end
        check("t6_tvalid_empty", 32'(trace_valid_o), 32'd0);
        exp_q.push_back({1'b0, 16'd1});
        send(1, 0, 100, 0);
        check("t6_ovf_cleared", 32'(trace_ovf_o), 32'd0);
        wait_done("t6b");
`endif

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
